// File: rtl/byte_result_pipe_if.sv
// Byte-unit writeback bus: stage-3 result in, RegTable writeback and forwarding out.
// Ports: wb_* / branch_is_taken / fwd_addr_* flow into the pipe (driven by the master);
//        rt_*, fwd_data_*/fwd_hit_* and writes_retired flow back out (driven by the slave).
interface byte_result_pipe_if;
  logic [0:127] wb_data;
  logic [0:6]   wb_reg_addr;
  logic         wb_enable_reg_write;
  logic         branch_is_taken;
  logic [0:6]   fwd_addr_a;
  logic [0:6]   fwd_addr_b;
  logic [0:127] rt_data;
  logic [0:6]   rt_addr;
  logic         rt_reg_write;
  logic [0:127] fwd_data_a;
  logic         fwd_hit_a;
  logic [0:127] fwd_data_b;
  logic         fwd_hit_b;
  logic [31:0]  writes_retired;

  // Producer side: the byte unit / decode stage feeding the pipe.
  modport master (
    output wb_data, wb_reg_addr, wb_enable_reg_write, branch_is_taken,
    output fwd_addr_a, fwd_addr_b,
    input  rt_data, rt_addr, rt_reg_write,
    input  fwd_data_a, fwd_hit_a, fwd_data_b, fwd_hit_b, writes_retired
  );

  // The result pipe itself.
  modport slave (
    input  wb_data, wb_reg_addr, wb_enable_reg_write, branch_is_taken,
    input  fwd_addr_a, fwd_addr_b,
    output rt_data, rt_addr, rt_reg_write,
    output fwd_data_a, fwd_hit_a, fwd_data_b, fwd_hit_b, writes_retired
  );
endinterface

// File: rtl/byte_result_pipe.sv
// Purpose: 4-deep result shift pipe (S4..S7) for the Byte unit with RegTable writeback
//          from S7, two combinational forwarding lookups and a retired-write counter.
// Latency: input to rt_* exactly 4 rising edges; forwarding is combinational from S4..S7.
// Backpressure: none -- the pipe shifts every edge; a taken branch squashes only the capture.
// Ports: clock, reset (async, active-high); bus (slave modport of byte_result_pipe_if).
module byte_result_pipe #(
  parameter int FIRST_STAGE = 4
) (
  input  logic             clock,
  input  logic             reset,
  byte_result_pipe_if.slave bus
);

  typedef struct packed {
    logic [0:127] data;
    logic [0:6]   addr;
    logic         wr;
  } entry_t;

  typedef struct packed {
    logic         hit;
    logic [0:127] data;
  } fwd_t;

  // Stage numbers are labels only; storage index 0 is the capture stage.
  localparam int STAGE_WB = FIRST_STAGE + 3;

  function automatic int stage_idx(input int stage);
    return stage - FIRST_STAGE;
  endfunction

  localparam int WB_IDX = stage_idx(STAGE_WB);

  entry_t [3:0] stage_q;
  entry_t       cap_d;
  logic [31:0]  retired_q;
  logic [31:0]  retired_d;
  fwd_t         fwd_a;
  fwd_t         fwd_b;

  // Youngest-wins lookup: scan oldest to youngest so a younger match overwrites.
  function automatic fwd_t lookup(input logic [0:6] a, input entry_t [3:0] st);
    fwd_t r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (st[i].wr && (st[i].addr == a)) begin
        r.hit  = 1'b1;
        r.data = st[i].data;
      end
    end
    return r;
  endfunction

  always_comb begin
    cap_d      = '0;
    cap_d.data = bus.wb_data;
    cap_d.addr = bus.wb_reg_addr;
    // A taken branch kills only the result being captured; older entries still retire.
    cap_d.wr   = bus.wb_enable_reg_write & ~bus.branch_is_taken;
  end

  always_comb begin
    retired_d = retired_q;
    if (stage_q[WB_IDX].wr) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_comb begin
    fwd_a = lookup(bus.fwd_addr_a, stage_q);
    fwd_b = lookup(bus.fwd_addr_b, stage_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_q   <= '0;
      retired_q <= '0;
    end else begin
      stage_q[0] <= cap_d;
      for (int i = 1; i < 4; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      retired_q <= retired_d;
    end
  end

  assign bus.rt_data        = stage_q[WB_IDX].data;
  assign bus.rt_addr        = stage_q[WB_IDX].addr;
  assign bus.rt_reg_write   = stage_q[WB_IDX].wr;
  assign bus.fwd_hit_a      = fwd_a.hit;
  assign bus.fwd_data_a     = fwd_a.data;
  assign bus.fwd_hit_b      = fwd_b.hit;
  assign bus.fwd_data_b     = fwd_b.data;
  assign bus.writes_retired = retired_q;

endmodule

// File: tb/tb_byte_result_pipe.sv
// Scoreboard bench for byte_result_pipe: each issued write pushes its expected
// writeback (cycle, addr, data); a monitor pops and compares whenever rt_reg_write is seen.
module tb_byte_result_pipe;

  logic clock = 1'b0;
  logic reset = 1'b1;

  byte_result_pipe_if bus();

  byte_result_pipe #(.FIRST_STAGE(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int           cyc;
    logic [0:6]   addr;
    logic [0:127] data;
  } exp_t;

  exp_t exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  localparam logic [0:127] D0123 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [0:127] DAA   = {16{8'hAA}};
  localparam logic [0:127] DBB   = {16{8'hBB}};
  localparam logic [0:127] D9    = 128'h99990000_11112222_33334444_55556666;
  localparam logic [0:127] D3    = 128'h33330000_77778888_9999AAAA_BBBBCCCC;
  localparam logic [0:127] D6    = 128'h66666666_00000000_FFFFFFFF_12345678;
  localparam logic [0:127] DZ    = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Inputs change on the falling edge; the next rising edge captures them into S4,
  // and the entry shows on rt_* after the fourth rising edge counted from there.
  task automatic drive(input logic we, input logic br, input logic [0:6] a, input logic [0:127] d);
    @(negedge clock);
    bus.wb_enable_reg_write = we;
    bus.branch_is_taken     = br;
    bus.wb_reg_addr         = a;
    bus.wb_data             = d;
    if (we && !br) exp_q.push_back('{cyc: cyc + 4, addr: a, data: d});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 7'd0, '0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.wb_enable_reg_write = 1'b0;
    bus.branch_is_taken     = 1'b0;
    #1 reset = 1'b1;
    #2 exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Monitor: every retirement must match the oldest expectation at its exact cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_total++;
        $display("FAIL missed_retire: addr %0d not seen, required at cycle %0d (now %0d)",
                 exp_q[0].addr, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (bus.rt_reg_write === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          n_total++;
          $display("FAIL unexpected_retire: rt_reg_write=1 addr %0d at cycle %0d, required 0",
                   bus.rt_addr, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rt_addr", 128'(bus.rt_addr), 128'(e.addr));
          chk("rt_data", bus.rt_data, e.data);
        end
      end
    end
  end

  initial begin
    bus.wb_data             = '0;
    bus.wb_reg_addr         = '0;
    bus.wb_enable_reg_write = 1'b0;
    bus.branch_is_taken     = 1'b0;
    bus.fwd_addr_a          = '0;
    bus.fwd_addr_b          = '0;

    // Reset state, checked while reset is still high.
    #3;
    chk("reset_rt_reg_write", 128'(bus.rt_reg_write), 128'd0);
    chk("reset_rt_addr", 128'(bus.rt_addr), 128'd0);
    chk("reset_rt_data", bus.rt_data, 128'd0);
    chk("reset_fwd_hit_a", 128'(bus.fwd_hit_a), 128'd0);
    chk("reset_fwd_data_b", bus.fwd_data_b, 128'd0);
    chk("reset_writes_retired", 128'(bus.writes_retired), 128'd0);
    #3 reset = 1'b0;

    // Single write to r3, retires 4 edges later exactly once.
    drive(1'b1, 1'b0, 7'd3, D0123);
    idle(5);
    chk("t1_writes_retired", 128'(bus.writes_retired), 128'd1);
    chk("t1_queue_drained", 128'(exp_q.size()), 128'd0);

    // Same capture squashed by a taken branch.
    do_reset();
    bus.fwd_addr_a = 7'd3;
    drive(1'b1, 1'b1, 7'd3, D0123);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      #1 chk("t2_fwd_hit_a_squashed", 128'(bus.fwd_hit_a), 128'd0);
    end
    // Squashed entry is in S7: data/addr travelled, the write enable did not.
    chk("t2_rt_addr_carried", 128'(bus.rt_addr), 128'd3);
    chk("t2_rt_data_carried", bus.rt_data, D0123);
    chk("t2_rt_reg_write", 128'(bus.rt_reg_write), 128'd0);
    idle(2);
    chk("t2_writes_retired", 128'(bus.writes_retired), 128'd0);
    // Branch squashes only the capture; the older write to r7 still retires.
    drive(1'b1, 1'b0, 7'd7, D6);
    drive(1'b1, 1'b1, 7'd8, D9);
    idle(5);
    chk("t2_older_retires", 128'(bus.writes_retired), 128'd1);

    // Back-to-back writes to r5: youngest wins, current-cycle inputs never forward.
    do_reset();
    bus.fwd_addr_a = 7'd5;
    drive(1'b1, 1'b0, 7'd5, DAA);
    drive(1'b1, 1'b0, 7'd5, DBB);
    #1;
    chk("t3_hit_a_s4_aa", 128'(bus.fwd_hit_a), 128'd1);
    chk("t3_data_a_not_input", bus.fwd_data_a, DAA);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      #1;
      chk("t3_hit_a_bb", 128'(bus.fwd_hit_a), 128'd1);
      chk("t3_data_a_bb", bus.fwd_data_a, DBB);
    end
    idle(1);
    #1;
    chk("t3_hit_a_after_retire", 128'(bus.fwd_hit_a), 128'd0);
    chk("t3_data_a_after_retire", bus.fwd_data_a, 128'd0);

    // Independent lookups: r3 in S5, r9 in S7.
    do_reset();
    drive(1'b1, 1'b0, 7'd9, D9);
    idle(1);
    drive(1'b1, 1'b0, 7'd3, D3);
    idle(2);
    bus.fwd_addr_a = 7'd3;
    bus.fwd_addr_b = 7'd9;
    #1;
    chk("t4_hit_a", 128'(bus.fwd_hit_a), 128'd1);
    chk("t4_data_a", bus.fwd_data_a, D3);
    chk("t4_hit_b", 128'(bus.fwd_hit_b), 128'd1);
    chk("t4_data_b", bus.fwd_data_b, D9);
    bus.fwd_addr_b = 7'd10;
    #1;
    chk("t4_miss_hit_b", 128'(bus.fwd_hit_b), 128'd0);
    chk("t4_miss_data_b", bus.fwd_data_b, 128'd0);
    bus.fwd_addr_b = 7'd3;
    #1;
    chk("t4_same_hit_b", 128'(bus.fwd_hit_b), 128'd1);
    chk("t4_same_data_b", bus.fwd_data_b, D3);
    chk("t4_same_data_a", bus.fwd_data_a, D3);
    idle(4);
    chk("t4_writes_retired", 128'(bus.writes_retired), 128'd2);

    // Async reset between edges with S4..S7 all valid.
    drive(1'b1, 1'b0, 7'd1, D9);
    drive(1'b1, 1'b0, 7'd2, D3);
    drive(1'b1, 1'b0, 7'd3, D6);
    drive(1'b1, 1'b0, 7'd4, DZ);
    idle(1);
    bus.fwd_addr_a = 7'd4;
    #1;
    chk("t5_hit_before_reset", 128'(bus.fwd_hit_a), 128'd1);
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("t5_rt_reg_write", 128'(bus.rt_reg_write), 128'd0);
    chk("t5_rt_addr", 128'(bus.rt_addr), 128'd0);
    chk("t5_rt_data", bus.rt_data, 128'd0);
    chk("t5_fwd_hit_a", 128'(bus.fwd_hit_a), 128'd0);
    chk("t5_fwd_data_a", bus.fwd_data_a, 128'd0);
    chk("t5_writes_retired", 128'(bus.writes_retired), 128'd0);
    #1 reset = 1'b0;
    idle(6);
    chk("t5_no_retire_after_release", 128'(bus.writes_retired), 128'd0);
    drive(1'b1, 1'b0, 7'd6, D6);
    idle(5);
    chk("t5_new_capture_retires", 128'(bus.writes_retired), 128'd1);

    // Address 0 is ordinary; counter wraps from all-ones to zero.
    do_reset();
    bus.fwd_addr_a = 7'd0;
    drive(1'b1, 1'b0, 7'd0, DZ);
    idle(1);
    #1;
    chk("t6_addr0_hit", 128'(bus.fwd_hit_a), 128'd1);
    chk("t6_addr0_data", bus.fwd_data_a, DZ);
    idle(3);
    force dut.retired_q = 32'hFFFF_FFFF;
    #2;
    release dut.retired_q;
    idle(1);
    #1;
    chk("t6_counter_wrap", 128'(bus.writes_retired), 128'd0);
    chk("t6_queue_drained", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
